// File: rtl/regfile.sv
// Three-port register file for a single-cycle RISC-V datapath: two combinational
// read ports and one synchronous write port. x0 is hardwired to zero.
module regfile #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2,
    input  logic [4:0]       a3,
    input  logic [WIDTH-1:0] wd3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(0);

    // x1..x(DEPTH-1); x0 has no storage
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    logic wr_en;
    assign wr_en = we3 && (a3 != ZERO_ADDR);

    // Reset wins over a coincident write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[a3] <= wd3;
        end
    end

    // No write-to-read bypass, so the read path never loops back through the ALU
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != ZERO_ADDR) rd1 = regs[a1];
        if (a2 != ZERO_ADDR) rd2 = regs[a2];
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected read data, a negedge
// monitor pops and compares against rd1/rd2.
module tb_regfile;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             we3;
    logic [4:0]       a1;
    logic [4:0]       a2;
    logic [4:0]       a3;
    logic [WIDTH-1:0] wd3;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    logic chk;

    typedef struct {
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        string            name;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    regfile #(.WIDTH(WIDTH), .DEPTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .we3  (we3),
        .a1   (a1),
        .a2   (a2),
        .a3   (a3),
        .wd3  (wd3),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    always #5 clk = ~clk;

    // Monitor: compare at the falling edge whenever stimulus flags a read
    always @(negedge clk) begin
        if (chk) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: read presented with no expected entry");
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (rd1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1);
                end
                n_checks++;
                if (rd2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2);
                end
            end
        end
    end

    task automatic expect_read(input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                               input string name);
        exp_t e;
        a1 = ra1;
        a2 = ra2;
        e.e1 = e1;
        e.e2 = e2;
        e.name = name;
        exp_q.push_back(e);
        chk = 1'b1;
        @(negedge clk);
        #1 chk = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [WIDTH-1:0] data);
        we3 = 1'b1;
        a3  = addr;
        wd3 = data;
        @(posedge clk);
        #1 we3 = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            expect_read(5'(i), 5'(31 - i), '0, '0, name);
        end
    endtask

    initial begin
        reset = 1'b0;
        we3   = 1'b0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        wd3   = '0;
        chk   = 1'b0;
        @(posedge clk);
        #1;

        // Reset one cycle then every address reads zero
        pulse_reset();
        sweep_zero("reset_sweep");

        // First edge after reset accepts a write
        write_reg(5'd5, 32'h0000000F);
        write_reg(5'd6, 32'h0000005A);
        expect_read(5'd5, 5'd6, 32'h0000000F, 32'h0000005A, "wr_x5_x6");
        expect_read(5'd6, 5'd6, 32'h0000005A, 32'h0000005A, "same_addr");
        expect_read(5'd0, 5'd0, '0, '0, "x0_read");

        // Write to x0 is discarded and disturbs nothing
        write_reg(5'd0, 32'hFFFFFFFF);
        expect_read(5'd0, 5'd5, '0, 32'h0000000F, "x0_write");
        expect_read(5'd6, 5'd0, 32'h0000005A, '0, "x0_write_side");

        // we3 = 0 leaves the addressed register alone
        we3 = 1'b0;
        a3  = 5'd5;
        wd3 = 32'hAAAAAAAA;
        @(posedge clk);
        #1;
        expect_read(5'd5, 5'd6, 32'h0000000F, 32'h0000005A, "we_low");

        // Old value before the edge, new value after it
        write_reg(5'd7, 32'h11111111);
        we3 = 1'b1;
        a3  = 5'd7;
        wd3 = 32'h22222222;
        expect_read(5'd7, 5'd7, 32'h11111111, 32'h11111111, "pre_edge");
        @(posedge clk);
        #1 we3 = 1'b0;
        expect_read(5'd7, 5'd5, 32'h22222222, 32'h0000000F, "post_edge");

        // Reset beats a coincident write and clears earlier writes
        write_reg(5'd31, 32'hDEADBEEF);
        expect_read(5'd31, 5'd1, 32'hDEADBEEF, '0, "x31_loaded");
        reset = 1'b1;
        we3   = 1'b1;
        a3    = 5'd31;
        wd3   = 32'h12345678;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we3   = 1'b0;
        expect_read(5'd31, 5'd5, '0, '0, "reset_over_write");
        sweep_zero("reset_discard_sweep");

        // Unknown write data with we3 = 0 for three cycles
        write_reg(5'd1, 32'h00000001);
        we3 = 1'b0;
        a3  = 5'd1;
        wd3 = 'x;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            expect_read(5'd1, 5'd1, 32'h00000001, 32'h00000001, "x_data_hold");
        end
        wd3 = '0;

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
